// File: rtl/mac_feeder_pkg.sv
// Shared definitions for the MAC feeder: FSM encoding, drain length and
// Q12.20 reference constants.
package mac_feeder_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_LOAD  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_ISSUE = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam int unsigned DRAIN_CYCLES = 2;

  localparam logic [31:0] ONE      = 32'h0010_0000;
  localparam int unsigned SIGN_BIT = 31;

  function automatic int unsigned idx_width(input int unsigned s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/mac_feeder_if.sv
// Load and result handshake bundle between the layer controller (master)
// and the MAC feeder (slave).
interface mac_feeder_if #(
  parameter int unsigned n = 32
);
  logic         load_valid;
  logic         load_ready;
  logic [n-1:0] load_w;
  logic [n-1:0] load_x;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_sum;
  logic         out_invalid;

  modport master (
    output load_valid, load_w, load_x, out_ready,
    input  load_ready, out_valid, out_sum, out_invalid
  );

  modport slave (
    input  load_valid, load_w, load_x, out_ready,
    output load_ready, out_valid, out_sum, out_invalid
  );
endinterface

// File: rtl/mac_feeder_buf.sv
// S-entry {w,x} register file: one write port, one combinational read port.
module mac_feeder_buf
  import mac_feeder_pkg::*;
#(
  parameter int unsigned S = 8,
  parameter int unsigned n = 32
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [idx_width(S)-1:0]    waddr_i,
  input  logic [2*n-1:0]             wdata_i,
  input  logic [idx_width(S)-1:0]    raddr_i,
  output logic [2*n-1:0]             rdata_o
);

  logic [2*n-1:0] mem_q [S];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mac_feeder.sv
// Buffers S weight/input pairs, clears the MAC, streams the pairs one per
// cycle, then returns the MAC's clamped sum and sticky invalid flag.
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int unsigned S = 8,
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         reset,
  mac_feeder_if.slave  bus,
  output logic [n-1:0] W,
  output logic [n-1:0] X,
  output logic         en_s2,
  output logic         local_en,
  output logic         mac_reset,
  input  logic [n-1:0] mac_sum,
  input  logic         mac_invalid,
  output logic         busy
);

  localparam int unsigned IW = idx_width(S);
  localparam logic [IW-1:0] LAST_IDX   = IW'(S - 1);
  localparam logic [IW-1:0] LAST_DRAIN = IW'(DRAIN_CYCLES - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   raddr;
  logic [n-1:0]    w_q, w_d, x_q, x_d;
  logic [n-1:0]    sum_q, sum_d;
  logic            inv_q, inv_d;
  logic            acc_q, acc_d;
  logic            valid_q, valid_d;
  logic            we;
  logic [2*n-1:0]  rdata;

  mac_feeder_buf #(
    .S (S),
    .n (n)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (idx_q),
    .wdata_i ({bus.load_w, bus.load_x}),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // W/X are registered one entry ahead so that during the ISSUE cycle with
  // index i the MAC already sees buffer[i]; CLEAR preloads entry 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_d     = w_q;
    x_d     = x_q;
    sum_d   = sum_q;
    inv_d   = inv_q;
    acc_d   = acc_q;
    valid_d = valid_q;
    we      = 1'b0;
    raddr   = idx_q;

    case (state_q)
      ST_LOAD: begin
        if (bus.load_valid) begin
          we = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_CLEAR;
            idx_d   = '0;
            acc_d   = 1'b0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_CLEAR: begin
        raddr   = '0;
        w_d     = rdata[2*n-1:n];
        x_d     = rdata[n-1:0];
        idx_d   = '0;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        acc_d = acc_q | mac_invalid;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          raddr = idx_q + IW'(1);
          w_d   = rdata[2*n-1:n];
          x_d   = rdata[n-1:0];
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DRAIN: begin
        if (idx_q == LAST_DRAIN) begin
          sum_d   = mac_sum;
          inv_d   = acc_q;
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      w_q     <= '0;
      x_q     <= '0;
      sum_q   <= '0;
      inv_q   <= 1'b0;
      acc_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      x_q     <= x_d;
      sum_q   <= sum_d;
      inv_q   <= inv_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
    end
  end

  assign W               = w_q;
  assign X               = x_q;
  assign en_s2           = (state_q == ST_ISSUE);
  assign local_en        = (state_q == ST_ISSUE);
  assign mac_reset       = !reset || (state_q == ST_CLEAR);
  assign busy            = (state_q != ST_LOAD);
  assign bus.load_ready  = (state_q == ST_LOAD);
  assign bus.out_valid   = valid_q;
  assign bus.out_sum     = sum_q;
  assign bus.out_invalid = inv_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder driving a behavioural sign-magnitude Q12.20
// MAC; expected results are queued at load time and checked by a monitor.
module tb_mac_feeder;
  import mac_feeder_pkg::*;

  localparam int unsigned S  = 8;
  localparam int unsigned NW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NW-1:0] W, X, mac_sum;
  logic          en_s2, local_en, mac_reset, mac_invalid, busy;

  mac_feeder_if #(.n(NW)) bus ();

  mac_feeder #(.S(S), .n(NW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .W           (W),
    .X           (X),
    .en_s2       (en_s2),
    .local_en    (local_en),
    .mac_reset   (mac_reset),
    .mac_sum     (mac_sum),
    .mac_invalid (mac_invalid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: product stage then accumulate, ReLU clamp on output.
  logic [61:0] prod_full, prod_mag;
  longint      prod_val, p_q, macc_q;
  logic        pv_q;

  always_comb begin
    prod_full   = 62'(W[30:0]) * 62'(X[30:0]);
    prod_mag    = prod_full >> 20;
    mac_invalid = |prod_mag[61:31];
    if (mac_invalid)        prod_val = 0;
    else if (W[31] ^ X[31]) prod_val = -longint'(prod_mag);
    else                    prod_val = longint'(prod_mag);
    if (macc_q <= 0)                   mac_sum = '0;
    else if (macc_q > 64'h7FFF_FFFF)   mac_sum = 32'h7FFF_FFFF;
    else                               mac_sum = macc_q[31:0];
  end

  always @(posedge clk) begin
    if (mac_reset) begin
      p_q    <= 0;
      pv_q   <= 1'b0;
      macc_q <= 0;
    end else begin
      pv_q <= en_s2 && local_en;
      if (en_s2 && local_en) p_q <= prod_val;
      if (pv_q) macc_q <= macc_q + p_q;
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int en_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mac_reset)  en_cnt <= 0;
    else if (en_s2) en_cnt <= en_cnt + 1;
  end

  typedef struct {
    logic [31:0] sum;
    logic        inv;
    bit          chk_sum;
    int          t_last;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: latency and enable count on out_valid rise, result on handshake.
  logic prev_v = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (reset) begin
      if (en_s2 || local_en) chk("local_en_eq_en_s2", 32'(local_en), 32'(en_s2));
      if (bus.out_valid && !prev_v) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          chk("latency", 32'(cyc - sb[0].t_last), S + 3);
          chk("en_cycles", 32'(en_cnt), S);
        end
      end
      if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_sum) chk("out_sum", bus.out_sum, e.sum);
        chk("out_invalid", 32'(bus.out_invalid), 32'(e.inv));
      end
    end
    prev_v <= bus.out_valid;
  end

  logic [31:0] vw[S];
  logic [31:0] vx[S];
  int          gap[S];

  task automatic check_reset_vals(input string tag);
    chk({tag, "_load_ready"},  32'(bus.load_ready),  32'd1);
    chk({tag, "_out_valid"},   32'(bus.out_valid),   32'd0);
    chk({tag, "_out_sum"},     bus.out_sum,          32'd0);
    chk({tag, "_out_invalid"}, 32'(bus.out_invalid), 32'd0);
    chk({tag, "_W"},           W,                    32'd0);
    chk({tag, "_X"},           X,                    32'd0);
    chk({tag, "_en_s2"},       32'(en_s2),           32'd0);
    chk({tag, "_local_en"},    32'(local_en),        32'd0);
    chk({tag, "_mac_reset"},   32'(mac_reset),       32'd1);
    chk({tag, "_busy"},        32'(busy),            32'd0);
  endtask

  // Called at posedge+1 with the feeder in LOAD.
  task automatic load_pairs(input bit push, input logic [31:0] esum,
                            input logic einv, input bit chk_sum);
    for (int i = 0; i < S; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        bus.load_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.load_valid = 1'b1;
      bus.load_w     = vw[i];
      bus.load_x     = vx[i];
      chk("load_ready_in_load", 32'(bus.load_ready), 32'd1);
      @(posedge clk); #1;
    end
    bus.load_valid = 1'b0;
    bus.load_w     = '0;
    bus.load_x     = '0;
    if (push) sb.push_back('{esum, einv, chk_sum, cyc});
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 60 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      chk({tag, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic set_all(input logic [31:0] w, input logic [31:0] x);
    for (int i = 0; i < S; i++) begin
      vw[i]  = w;
      vx[i]  = x;
      gap[i] = 0;
    end
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_w     = '0;
    bus.load_x     = '0;
    bus.out_ready  = 1'b0;
    #1;
    check_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    bus.out_ready = 1'b1;

    set_all(ONE, 32'h0020_0000);
    load_pairs(1'b1, 32'h0100_0000, 1'b0, 1'b1);
    wait_done("basic");

    set_all(32'h8010_0000, ONE);
    load_pairs(1'b1, 32'h0000_0000, 1'b0, 1'b1);
    wait_done("relu");

    set_all(32'h0030_0000, ONE);
    for (int i = 4; i < S; i++) vw[i] = 32'h8010_0000;
    load_pairs(1'b1, 32'h0080_0000, 1'b0, 1'b1);
    wait_done("mixed");

    set_all(ONE, 32'h0020_0000);
    gap[1] = 2; gap[3] = 1; gap[4] = 3; gap[7] = 1;
    load_pairs(1'b1, 32'h0100_0000, 1'b0, 1'b1);
    wait_done("stall");

    bus.out_ready = 1'b0;
    set_all(32'h0030_0000, ONE);
    for (int i = 4; i < S; i++) vw[i] = 32'h8010_0000;
    load_pairs(1'b1, 32'h0080_0000, 1'b0, 1'b1);
    for (int k = 0; k < 30 && !bus.out_valid; k++) begin
      @(posedge clk); #1;
    end
    bus.load_valid = 1'b1;
    bus.load_w     = 32'hDEAD_BEEF;
    bus.load_x     = 32'h1234_5678;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid",  32'(bus.out_valid),  32'd1);
      chk("bp_out_sum",    bus.out_sum,         32'h0080_0000);
      chk("bp_load_ready", 32'(bus.load_ready), 32'd0);
      chk("bp_busy",       32'(busy),           32'd1);
    end
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    bus.out_ready  = 1'b1;
    @(posedge clk); #1;
    chk("bp_popped",          32'(sb.size()),      32'd0);
    chk("bp_after_valid",     32'(bus.out_valid),  32'd0);
    chk("bp_after_loadready", 32'(bus.load_ready), 32'd1);

    set_all(ONE, 32'h0020_0000);
    load_pairs(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 30 && en_cnt != 3; k++) begin
      @(posedge clk); #1;
    end
    chk("issue_idx3_reached", 32'(en_cnt), 32'd3);
    #2 reset = 1'b0;
    #1 check_reset_vals("midrst");
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1 chk("post_reset_no_valid", 32'(bus.out_valid), 32'd0);

    set_all(ONE, 32'h0020_0000);
    load_pairs(1'b1, 32'h0100_0000, 1'b0, 1'b1);
    wait_done("after_reset");

    set_all(ONE, ONE);
    vw[5] = 32'h7FF0_0000;
    vx[5] = 32'h7FF0_0000;
    load_pairs(1'b1, '0, 1'b1, 1'b0);
    wait_done("invalid");

    set_all(ONE, ONE);
    load_pairs(1'b1, 32'h0080_0000, 1'b0, 1'b1);
    wait_done("clean");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
